ahb_master_interface: RTL and testbench

AHB-Lite initiator that converts a simple valid/ready command stream into pipelined single NONSEQ transfers toward the AHB register slave (err_status, payload, data_size). It owns the address/data phase pipeline, honours slave wait states, handles the two-cycle ERROR response by cancelling and reissuing the pending address phase, and returns one response per command, in order. It sits between the control logic and the slave's hsel_x/haddr/htrans/hwrite/hsize/hwdata/hready inputs.

---
 rtl/ahb_master_interface.sv | 135 +++++++++++++
 tb/tb_ahb_master_interface.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master_interface.sv
// AHB-Lite initiator: turns a valid/ready command stream into single NONSEQ
// transfers with an address stage (A) and a data stage (D). On an ERROR
// response, the pending address phase is cancelled for one cycle and then
// reissued. Responses come back one per command, in command order.
`timescale 1ns/1ps
module ahb_master_interface #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [2:0]            cmd_size,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  hsel_x,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [1:0]            htrans,
  output logic                  hwrite,
  output logic [2:0]            hsize,
  output logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  input  logic                  hresp,
  input  logic [DATA_WIDTH-1:0] hrdata
);

  // Address stage
  logic                  r_a_valid;
  logic [ADDR_WIDTH-1:0] r_a_addr;
  logic                  r_a_write;
  logic [2:0]            r_a_size;
  logic [DATA_WIDTH-1:0] r_a_wdata;
  // Data stage
  logic                  r_d_valid;
  logic                  r_d_write;
  logic [DATA_WIDTH-1:0] r_d_wdata;
  // High for the second cycle of a two-cycle ERROR response
  logic                  r_err_cancel;
  // Registered response
  logic                  r_rsp_valid;
  logic                  r_rsp_write;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;

  logic w_nonseq;
  logic w_accept;
  logic w_a_done;
  logic w_d_done;

  // The address phase is suppressed while the slave is finishing an ERROR
  assign w_nonseq  = r_a_valid && !r_err_cancel;
  assign w_a_done  = hready && w_nonseq;
  assign w_d_done  = hready && r_d_valid;
  assign cmd_ready = !hreset && !r_err_cancel && (!r_a_valid || hready);
  assign w_accept  = cmd_valid && cmd_ready;

  assign htrans    = w_nonseq ? 2'b10 : 2'b00;
  assign hsel_x    = r_a_valid || r_d_valid;
  assign haddr     = r_a_valid ? r_a_addr  : '0;
  assign hwrite    = r_a_valid ? r_a_write : 1'b0;
  assign hsize     = r_a_valid ? r_a_size  : 3'd0;
  assign hwdata    = (r_d_valid && r_d_write) ? r_d_wdata : '0;

  assign rsp_valid = r_rsp_valid;
  assign rsp_write = r_rsp_write;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  // Address stage: load a new command, or empty when its phase completes
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_a_valid <= 1'b0;
      r_a_addr  <= '0;
      r_a_write <= 1'b0;
      r_a_size  <= 3'd0;
      r_a_wdata <= '0;
    end else if (w_accept) begin
      r_a_valid <= 1'b1;
      r_a_addr  <= cmd_addr;
      r_a_write <= cmd_write;
      r_a_size  <= cmd_size;
      r_a_wdata <= cmd_wdata;
    end else if (w_a_done) begin
      r_a_valid <= 1'b0;
    end
  end

  // Data stage: take over a completed address phase, or empty on completion
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_d_valid <= 1'b0;
      r_d_write <= 1'b0;
      r_d_wdata <= '0;
    end else if (w_a_done) begin
      r_d_valid <= 1'b1;
      r_d_write <= r_a_write;
      r_d_wdata <= r_a_wdata;
    end else if (w_d_done) begin
      r_d_valid <= 1'b0;
    end
  end

  // First ERROR cycle (hresp with hready low) cancels the next address phase
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_err_cancel <= 1'b0;
    end else begin
      r_err_cancel <= hresp && !hready;
    end
  end

  // Capture the response when the data phase completes
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_d_done;
      if (w_d_done) begin
        r_rsp_write <= r_d_write;
        r_rsp_rdata <= r_d_write ? '0 : hrdata;
        r_rsp_err   <= hresp;
      end
    end
  end

endmodule

// File: tb/tb_ahb_master_interface.sv
// Randomised scoreboard bench for ahb_master_interface with a behavioural
// AHB slave (8-byte memory, random wait states, address 7 answers ERROR).
`timescale 1ns/1ps
module tb_ahb_master_interface;
  logic       hclk = 1'b0;
  logic       hreset;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [2:0] cmd_addr, cmd_size;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_write, rsp_err;
  logic [7:0] rsp_rdata;
  logic       hsel_x, hwrite, hready, hresp;
  logic [2:0] haddr, hsize;
  logic [1:0] htrans;
  logic [7:0] hwdata, hrdata;

  ahb_master_interface #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) dut (
    .hclk(hclk), .hreset(hreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .hsel_x(hsel_x), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
    .hresp(hresp), .hrdata(hrdata)
  );

  always #5 hclk = ~hclk;

  typedef struct { logic w; logic [7:0] rd; logic e; } rsp_t;
  typedef struct { logic [2:0] a; logic w; logic [2:0] s; } aph_t;

  int   total = 0;
  int   bad   = 0;
  int   nrsp  = 0;
  rsp_t expq[$];
  aph_t aq[$];
  logic [7:0] mem_model [8];
  logic [7:0] slv_mem [8];
  logic [7:0] snap [8];

  // slave state
  bit         s_act, s_write, s_stage, prev_err, no_wait;
  logic [2:0] s_addr;
  int         s_wait;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each accepted command resolved in command order against a plain memory
  task automatic push_model(input logic w, input logic [2:0] a, input logic [2:0] s,
                            input logic [7:0] d);
    rsp_t r;
    aph_t p;
    r.w = w;
    r.e = (a == 3'd7);
    if (w) begin
      r.rd = 8'h00;
      if (!r.e) mem_model[a] = d;
    end else begin
      r.rd = r.e ? 8'hEE : mem_model[a];
    end
    expq.push_back(r);
    p.a = a; p.w = w; p.s = s;
    aq.push_back(p);
  endtask

  // Behavioural slave: decides this cycle's response and tracks its data phase
  task automatic slave_cycle();
    bit   done;
    aph_t p;
    done   = 0;
    hresp  = 1'b0;
    hready = 1'b1;
    hrdata = 8'($urandom);
    if (s_act) begin
      if (s_addr == 3'd7) begin
        if (!s_stage) begin
          hready = 1'b0; hresp = 1'b1; s_stage = 1;
        end else begin
          hresp = 1'b1; done = 1;
          if (!s_write) hrdata = 8'hEE;
        end
      end else if (s_wait > 0) begin
        hready = 1'b0;
        s_wait--;
      end else begin
        done = 1;
        if (s_write) slv_mem[s_addr] = hwdata;
        else hrdata = slv_mem[s_addr];
      end
    end
    if (hready && hsel_x && htrans == 2'b10) begin
      if (aq.size() == 0) begin
        total++; bad++;
        $display("FAIL aphase_unexpected: got addr %0d expected none", haddr);
      end else begin
        p = aq.pop_front();
        check("aphase_addr", 32'(haddr), 32'(p.a));
        check("aphase_write", 32'(hwrite), 32'(p.w));
        check("aphase_size", 32'(hsize), 32'(p.s));
      end
      s_act = 1; s_addr = haddr; s_write = hwrite; s_stage = 0;
      s_wait = no_wait ? 0 : (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
    end else if (done) begin
      s_act = 0;
    end
  endtask

  task automatic step(input bit v, input bit w, input logic [2:0] a, input logic [2:0] s,
                      input logic [7:0] d, output bit acc);
    @(negedge hclk);
    if (prev_err) check("cancel_idle", 32'(htrans), 32'd0);
    slave_cycle();
    prev_err  = hresp && !hready;
    cmd_valid = v; cmd_write = w; cmd_addr = a; cmd_size = s; cmd_wdata = d;
    #1;
    acc = v && cmd_ready;
    if (acc) push_model(w, a, s, d);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(0, 0, 3'd0, 3'd0, 8'd0, acc);
  endtask

  task automatic issue(input bit w, input logic [2:0] a, input logic [2:0] s, input logic [7:0] d);
    bit acc;
    int n;
    n = 0;
    do begin
      step(1, w, a, s, d, acc);
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      total++; bad++;
      $display("FAIL accept_timeout: got cmd_ready=0 expected acceptance within 50 cycles");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 200) begin
      idle(1);
      n++;
    end
    check("drain_empty", 32'(expq.size()), 32'd0);
  endtask

  // Monitor: every response pops the oldest expectation
  always @(negedge hclk) begin
    if (rsp_valid) begin
      nrsp++;
      if (expq.size() == 0) begin
        total++; bad++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 expected none");
      end else begin
        rsp_t e;
        e = expq.pop_front();
        $display("rsp %0d: write=%0d rdata=%02h err=%0d", nrsp, rsp_write, rsp_rdata, rsp_err);
        check("rsp_write", 32'(rsp_write), 32'(e.w));
        check("rsp_rdata", 32'(rsp_rdata), 32'(e.rd));
        check("rsp_err", 32'(rsp_err), 32'(e.e));
      end
    end
  end

  initial begin
    hreset = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd5; cmd_size = 3'd2; cmd_wdata = 8'hA5;
    hready = 1'b1; hresp = 1'b0; hrdata = 8'h00;
    s_act = 0; s_write = 0; s_stage = 0; s_addr = 3'd0; s_wait = 0;
    prev_err = 0; no_wait = 1;
    for (int i = 0; i < 8; i++) begin mem_model[i] = 8'h00; slv_mem[i] = 8'h00; end

    // Reset values while hreset is high (a command is offered meanwhile)
    #12;
    check("rst_htrans", 32'(htrans), 32'd0);
    check("rst_hsel", 32'(hsel_x), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_haddr", 32'(haddr), 32'd0);
    check("rst_hwdata", 32'(hwdata), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    @(negedge hclk);
    hreset = 1'b0;
    cmd_valid = 1'b0;

    // Zero-wait write: address phase, data phase, then response
    issue(1, 3'd4, 3'd0, 8'd12);
    idle(1);
    check("lat_htrans", 32'(htrans), 32'h2);
    check("lat_haddr", 32'(haddr), 32'd4);
    check("lat_hwrite", 32'(hwrite), 32'd1);
    idle(1);
    check("lat_hwdata", 32'(hwdata), 32'd12);
    idle(1);
    check("lat_rsp_valid", 32'(rsp_valid), 32'd1);
    drain();

    // Back-to-back write then read; write data overlaps the read address phase
    issue(1, 3'd2, 3'd1, 8'h29);
    issue(0, 3'd4, 3'd0, 8'h00);
    idle(1);
    check("b2b_htrans", 32'(htrans), 32'h2);
    check("b2b_haddr", 32'(haddr), 32'd4);
    check("b2b_hwrite", 32'(hwrite), 32'd0);
    check("b2b_hwdata", 32'(hwdata), 32'h29);
    drain();

    // Error on a write followed by a pending read
    issue(1, 3'd7, 3'd0, 8'h11);
    issue(0, 3'd4, 3'd0, 8'h00);
    drain();

    // Reset during the address phase of a write: nothing in flight survives
    snap = mem_model;
    issue(1, 3'd4, 3'd0, 8'h55);
    @(negedge hclk);
    hreset = 1'b1;
    cmd_valid = 1'b0;
    #1;
    check("mid_rst_htrans", 32'(htrans), 32'd0);
    check("mid_rst_hsel", 32'(hsel_x), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    expq.delete();
    aq.delete();
    s_act = 0; prev_err = 0;
    mem_model = snap;
    @(negedge hclk);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge hclk);
    hreset = 1'b0;
    idle(4);
    issue(1, 3'd4, 3'd0, 8'h33);
    issue(0, 3'd4, 3'd0, 8'h00);
    drain();

    // Randomised traffic with wait states and errors
    no_wait = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0)
        issue(1'($urandom), 3'($urandom), 3'($urandom), 8'($urandom));
      else
        idle(1);
    end
    drain();
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000ns");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end
endmodule
